// File: rtl/iob_soc_opencryptolinux_iob_arbiter_pkg.sv
// Shared constants for the IOb round-robin arbiter.
//   - FSM state encodings (IDLE=0, REQ=1, RESP=2)
//   - default read data returned when the response watchdog expires
package iob_soc_opencryptolinux_iob_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;  // no owner
  localparam logic [1:0] ST_REQ  = 2'd1;  // owner's request forwarded to slave
  localparam logic [1:0] ST_RESP = 2'd2;  // read accepted, waiting for rvalid

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/iob_soc_opencryptolinux_iob_arbiter_rr_prio.sv
// iob_rr_prio: combinational round-robin priority picker.
// Picks the first set bit of req at or above ptr, searching upward and
// wrapping around at N.
//   req : N-bit request vector
//   ptr : index where the search starts
//   gnt : one-hot grant (zero when no request)
//   idx : encoded index of the granted bit
//   any : at least one request present
module iob_rr_prio #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // ptr + off, wrapped into 0..N-1 (off < N, so one subtraction suffices)
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p,
                                                 input int off);
    int s;
    s = int'(p) + off;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[wrap_idx(ptr, i)]) begin
        any                   = 1'b1;
        idx                   = wrap_idx(ptr, i);
        gnt[wrap_idx(ptr, i)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_soc_opencryptolinux_iob_arbiter.sv
// N-master to 1-slave round-robin arbiter on the IOb native bus.
// At most one transaction is in flight; a watchdog answers reads the slave
// never completes with ERR_DATA and sets a sticky timeout flag.
//
// Handshake: a master request is accepted in the cycle where it holds
// m_valid_i and sees its m_ready_o bit high; a read response is delivered in
// the single cycle where its m_rvalid_o bit is high, with data on m_rdata_o.
// Masters must hold valid (and address/data/strobe) until accepted.
//
// Ports:
//   clk_i, rst_i (sync, active-high), cke_i (clock enable, freezes state)
//   m_valid_i/m_addr_i/m_wdata_i/m_wstrb_i : packed per-master requests
//   m_rdata_o (shared), m_ready_o, m_rvalid_o (per master)
//   s_valid_o/s_addr_o/s_wdata_o/s_wstrb_o : request to the slave
//   s_rdata_i/s_ready_i/s_rvalid_i         : slave response
//   grant_o   : one-hot current owner, zero when idle
//   timeout_o : sticky watchdog-expired flag, cleared only by reset
module iob_soc_opencryptolinux_iob_arbiter
  import iob_soc_opencryptolinux_iob_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cke_i,
  input  logic [N_MASTERS-1:0]          m_valid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic [N_MASTERS-1:0]          m_ready_o,
  output logic [N_MASTERS-1:0]          m_rvalid_o,
  output logic                          s_valid_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_wdata_o,
  output logic [DATA_W/8-1:0]           s_wstrb_o,
  input  logic [DATA_W-1:0]             s_rdata_i,
  input  logic                          s_ready_i,
  input  logic                          s_rvalid_i,
  output logic [N_MASTERS-1:0]          grant_o,
  output logic                          timeout_o
);

  localparam int IDX_W  = $clog2(N_MASTERS);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

  logic [1:0]           state;
  logic [IDX_W-1:0]     owner;
  logic [N_MASTERS-1:0] owner_oh;
  logic [IDX_W-1:0]     rr_ptr;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 timeout_q;

  logic [N_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [IDX_W-1:0]     next_ptr;

  logic [31:0]          owner_base;
  logic                 owner_valid;
  logic [ADDR_W-1:0]    owner_addr;
  logic [DATA_W-1:0]    owner_wdata;
  logic [STRB_W-1:0]    owner_wstrb;
  logic                 in_req;
  logic                 in_resp;
  logic                 wd_expired;
  logic                 rsp_ok;
  logic                 rsp_to;

  iob_rr_prio #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_prio (
    .req (m_valid_i),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign next_ptr = (pick_idx == IDX_W'(N_MASTERS - 1)) ? '0 : pick_idx + IDX_W'(1);

  assign owner_base  = 32'(owner);
  assign owner_valid = m_valid_i[owner];
  assign owner_addr  = m_addr_i[owner_base*ADDR_W +: ADDR_W];
  assign owner_wdata = m_wdata_i[owner_base*DATA_W +: DATA_W];
  assign owner_wstrb = m_wstrb_i[owner_base*STRB_W +: STRB_W];

  assign in_req     = (state == ST_REQ);
  assign in_resp    = (state == ST_RESP);
  assign wd_expired = in_resp && (wd_cnt == WD_MAX);
  // A real response wins over an expiry landing in the same cycle.
  assign rsp_ok     = in_resp && s_rvalid_i;
  assign rsp_to     = wd_expired && !s_rvalid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      owner     <= '0;
      owner_oh  <= '0;
      rr_ptr    <= '0;
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (cke_i) begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state    <= ST_REQ;
            owner    <= pick_idx;
            owner_oh <= pick_gnt;
            rr_ptr   <= next_ptr;
          end
        end
        ST_REQ: begin
          // An owner that withdraws before acceptance aborts; a ready seen
          // with rvalid in the same cycle counts only as acceptance.
          if (!owner_valid) begin
            state <= ST_IDLE;
          end else if (s_ready_i) begin
            if (|owner_wstrb) begin
              state <= ST_IDLE;
            end else begin
              state  <= ST_RESP;
              wd_cnt <= '0;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ok) begin
            state <= ST_IDLE;
          end else if (wd_expired) begin
            state     <= ST_IDLE;
            timeout_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + TIMEOUT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Everything below is a pure function of the (possibly frozen) state and
  // the current inputs.
  assign grant_o    = (state != ST_IDLE) ? owner_oh : '0;
  assign timeout_o  = timeout_q;

  assign s_valid_o  = in_req && owner_valid;
  assign s_addr_o   = in_req ? owner_addr  : '0;
  assign s_wdata_o  = in_req ? owner_wdata : '0;
  assign s_wstrb_o  = in_req ? owner_wstrb : '0;

  assign m_ready_o  = (in_req && s_ready_i) ? owner_oh : '0;
  assign m_rvalid_o = (rsp_ok || rsp_to) ? owner_oh : '0;
  assign m_rdata_o  = rsp_to  ? ERR_DATA  :
                      in_resp ? s_rdata_i : '0;

endmodule

// File: tb/tb_iob_soc_opencryptolinux_iob_arbiter.sv
module tb_iob_soc_opencryptolinux_iob_arbiter;

  localparam int N  = 2;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TW = 4;

  logic            clk;
  logic            rst;
  logic            cke;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_ready;
  logic [N-1:0]    m_rvalid;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            s_ready;
  logic            s_rvalid;
  logic [N-1:0]    grant;
  logic            timeout;

  int checks = 0;
  int errors = 0;
  logic [N+DW-1:0] exp_q[$];

  iob_soc_opencryptolinux_iob_arbiter #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT_W (TW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cke_i      (cke),
    .m_valid_i  (m_valid),
    .m_addr_i   (m_addr),
    .m_wdata_i  (m_wdata),
    .m_wstrb_i  (m_wstrb),
    .m_rdata_o  (m_rdata),
    .m_ready_o  (m_ready),
    .m_rvalid_o (m_rvalid),
    .s_valid_o  (s_valid),
    .s_addr_o   (s_addr),
    .s_wdata_o  (s_wdata),
    .s_wstrb_o  (s_wstrb),
    .s_rdata_i  (s_rdata),
    .s_ready_i  (s_ready),
    .s_rvalid_i (s_rvalid),
    .grant_o    (grant),
    .timeout_o  (timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_grant"},   64'(grant),    64'(0));
    check({tag, "_timeout"}, 64'(timeout),  64'(0));
    check({tag, "_mready"},  64'(m_ready),  64'(0));
    check({tag, "_mrvalid"}, 64'(m_rvalid), 64'(0));
    check({tag, "_svalid"},  64'(s_valid),  64'(0));
    check({tag, "_saddr"},   64'(s_addr),   64'(0));
    check({tag, "_swdata"},  64'(s_wdata),  64'(0));
    check({tag, "_swstrb"},  64'(s_wstrb),  64'(0));
    check({tag, "_mrdata"},  64'(m_rdata),  64'(0));
    check({tag, "_rr_ptr"},  64'(dut.rr_ptr), 64'(0));
  endtask

  // scoreboard: every response the masters see must match the queue head
  always @(negedge clk) begin
    if (m_rvalid !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 64'(m_rvalid), 64'(0));
      end else begin
        logic [N+DW-1:0] e;
        e = exp_q.pop_front();
        check("rsp", 64'({m_rvalid, m_rdata}), 64'(e));
      end
    end
  end

  initial begin
    logic [N-1:0] eg;
    rst = 1'b1; cke = 1'b1;
    m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_rdata = '0; s_ready = 1'b0; s_rvalid = 1'b0;
    tick(); tick();
    #1 check_reset_values("reset");
    rst = 1'b0;

    // single write from master 1, slave ready in first REQ cycle
    m_valid = 2'b10;
    m_addr[AW +: AW]  = 12'h010;
    m_wdata[DW +: DW] = 32'hA5A5_A5A5;
    m_wstrb[SW +: SW] = 4'hF;
    tick();
    #1;
    check("wr_grant",  64'(grant),   64'(2'b10));
    check("wr_svalid", 64'(s_valid), 64'(1));
    check("wr_saddr",  64'(s_addr),  64'(12'h010));
    check("wr_swdata", 64'(s_wdata), 64'(32'hA5A5_A5A5));
    check("wr_swstrb", 64'(s_wstrb), 64'(4'hF));
    check("wr_mready_pre", 64'(m_ready), 64'(0));
    s_ready = 1'b1;
    #1 check("wr_mready", 64'(m_ready), 64'(2'b10));
    tick();
    m_valid = '0; s_ready = 1'b0; m_wstrb = '0;
    #1;
    check("wr_idle_grant",  64'(grant),      64'(0));
    check("wr_idle_mready", 64'(m_ready),    64'(0));
    check("wr_rr_ptr",      64'(dut.rr_ptr), 64'(0));

    // read from master 0: ready after 2 REQ cycles, rvalid 3 RESP cycles later
    m_valid = 2'b01;
    m_addr[0 +: AW] = 12'h004;
    tick();
    #1;
    check("rd_grant1", 64'(grant),   64'(2'b01));
    check("rd_saddr",  64'(s_addr),  64'(12'h004));
    check("rd_swstrb", 64'(s_wstrb), 64'(0));
    tick();
    #1;
    check("rd_grant2", 64'(grant),   64'(2'b01));
    check("rd_wait",   64'(m_ready), 64'(0));
    tick();
    s_ready = 1'b1;
    exp_q.push_back({2'b01, 32'h1234_5678});
    #1 check("rd_mready", 64'(m_ready), 64'(2'b01));
    tick();
    s_ready = 1'b0; m_valid = '0;
    #1;
    check("rd_resp_grant",  64'(grant),    64'(2'b01));
    check("rd_resp_svalid", 64'(s_valid),  64'(0));
    check("rd_resp_quiet",  64'(m_rvalid), 64'(0));
    tick();
    #1 check("rd_resp_grant2", 64'(grant), 64'(2'b01));
    tick();
    s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    check("rd_grant3", 64'(grant),    64'(2'b01));
    check("rd_rvalid", 64'(m_rvalid), 64'(2'b01));
    check("rd_rdata",  64'(m_rdata),  64'(32'h1234_5678));
    tick();
    s_rvalid = 1'b0;
    #1;
    check("rd_done_grant",  64'(grant),    64'(0));
    check("rd_done_rvalid", 64'(m_rvalid), 64'(0));
    check("rd_rr_ptr",      64'(dut.rr_ptr), 64'(1));

    // fairness: both masters write continuously, slave always ready
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_addr = {12'h200, 12'h100};
    m_wdata = {32'h1111_0001, 32'h0000_0000};
    m_wstrb = {4'hF, 4'hF};
    s_ready = 1'b1;
    m_valid = 2'b11;
    for (int i = 0; i < 12; i++) begin
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      #1;
      check("fair_grant",  64'(grant),   64'(eg));
      check("fair_mready", 64'(m_ready), 64'(eg));
      check("fair_saddr",  64'(s_addr),  64'((i % 2 == 0) ? 12'h100 : 12'h200));
      tick();
      if (i == 11) m_valid = '0;
      #1 check("fair_bubble", 64'(grant), 64'(0));
    end
    s_ready = 1'b0; m_wstrb = '0;

    // timeout: read from master 0 that never gets rvalid
    m_addr[0 +: AW] = 12'h020;
    m_valid = 2'b01;
    tick();
    s_ready = 1'b1;
    exp_q.push_back({2'b01, 32'hDEAD_BEEF});
    tick();
    s_ready = 1'b0; m_valid = '0;
    for (int j = 0; j < 15; j++) begin
      #1 check("to_quiet", 64'(m_rvalid), 64'(0));
      tick();
    end
    #1;
    check("to_rvalid", 64'(m_rvalid), 64'(2'b01));
    check("to_rdata",  64'(m_rdata),  64'(32'hDEAD_BEEF));
    tick();
    #1;
    check("to_flag",  64'(timeout), 64'(1));
    check("to_idle",  64'(grant),   64'(0));
    repeat (3) tick();
    #1 check("to_sticky", 64'(timeout), 64'(1));

    // abort: owner drops valid while in REQ
    m_addr[AW +: AW] = 12'h030;
    m_wstrb[SW +: SW] = 4'hF;
    m_valid = 2'b10;
    tick();
    #1 check("ab_grant", 64'(grant), 64'(2'b10));
    m_valid = '0;
    #1;
    check("ab_mready", 64'(m_ready), 64'(0));
    check("ab_svalid", 64'(s_valid), 64'(0));
    tick();
    #1;
    check("ab_idle",   64'(grant),   64'(0));
    check("ab_sticky", 64'(timeout), 64'(1));
    m_wstrb = '0;

    // reset while in RESP, then a late rvalid from the slave
    m_addr[0 +: AW] = 12'h040;
    m_valid = 2'b01;
    tick();
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0; m_valid = '0;
    #1 check("rr_resp_grant", 64'(grant), 64'(2'b01));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 check_reset_values("mid_reset");
    s_rvalid = 1'b1; s_rdata = 32'hBAD0_BAD0;
    #1;
    check("stray_rvalid", 64'(m_rvalid), 64'(0));
    check("stray_rdata",  64'(m_rdata),  64'(0));
    tick();
    s_rvalid = 1'b0;
    #1 check("stray_idle", 64'(dut.state), 64'(0));

    // clock enable low for 5 cycles in RESP
    m_addr[AW +: AW] = 12'h050;
    m_valid = 2'b10;
    tick();
    #1 check("cke_grant", 64'(grant), 64'(2'b10));
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0; m_valid = '0;
    tick(); tick();
    cke = 1'b0;
    #1 check("cke_wd_before", 64'(dut.wd_cnt), 64'(2));
    repeat (5) tick();
    #1;
    check("cke_wd_frozen", 64'(dut.wd_cnt), 64'(2));
    check("cke_grant_hold", 64'(grant),     64'(2'b10));
    cke = 1'b1;
    tick();
    #1 check("cke_wd_resume", 64'(dut.wd_cnt), 64'(3));
    s_rvalid = 1'b1; s_rdata = 32'hCAFE_F00D;
    exp_q.push_back({2'b10, 32'hCAFE_F00D});
    #1 check("cke_rvalid", 64'(m_rvalid), 64'(2'b10));
    tick();
    s_rvalid = 1'b0;
    #1 check("cke_done", 64'(grant), 64'(0));

    repeat (2) tick();
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
